imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter REG_SIZE, default 32, meaning data/address width.
REQ-002 SHALL have parameter MEM_SIZE_IN_KB, default 1, meaning instruction memory size.
REQ-003 SHALL have parameter NO_OF_REGS, default MEM_SIZE_IN_KB*1024/4, meaning word capacity.
REQ-004 SHALL have port clk, input, 1, meaning the single clock, with all state rising-edge triggered.
REQ-005 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port start_i, input, 1, meaning a load request pulse.
REQ-007 SHALL have port byte_i, input, 8, meaning the incoming stream byte.
REQ-008 SHALL have port byte_valid_i, input, 1, meaning byte_i is valid.
REQ-009 SHALL have port byte_ready_o, output, 1, meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en_o, output, 1, meaning the instruction memory write strobe.
REQ-011 SHALL have port wr_addr_o, output, REG_SIZE, meaning the byte address (word-aligned, bits [1:0]=0).
REQ-012 SHALL have port wr_data_o, output, REG_SIZE, meaning the instruction word.
REQ-013 SHALL have port core_rst_o, output, 1, meaning the core is held in reset while loading.
REQ-014 SHALL have port busy_o, done_o, err_o, output, 1 each, meaning status.

Function
REQ-015 SHALL accept a byte only when byte_valid_i && byte_ready_o in the same cycle.
REQ-016 SHALL use the FSM states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-017 SHALL, in IDLE, keep byte_ready_o=0 and move to LEN on start_i=1; while busy, start_i SHALL be ignored.
REQ-018 SHALL, in LEN, accept 4 bytes little-endian into word count N; after the 4th byte, N=0 SHALL go to DONE, N>NO_OF_REGS SHALL go to ERR, else DATA.
REQ-019 SHALL, in DATA, accept 4 bytes little-endian (first byte -> bits [7:0]) into the assembly register, then go to WRITE.
REQ-020 SHALL, in WRITE, assert wr_en_o for exactly one cycle with byte_ready_o=0, wr_addr_o=word_idx*4 and wr_data_o=the assembled word.
REQ-021 SHALL, after WRITE, increment word_idx and return to DATA if word_idx<N, else go to DONE.
REQ-022 SHALL, in DONE, hold done_o=1 for one cycle, then return to IDLE.
REQ-023 SHALL, in ERR, hold err_o=1 until the next start_i, which SHALL clear the error and enter LEN.
REQ-024 SHALL drive busy_o=1 and core_rst_o=1 in LEN, DATA and WRITE; otherwise both SHALL be 0.
REQ-025 SHALL hold byte and word counters across cycles with byte_valid_i=0; no timeout.
REQ-026 SHALL never issue an address ≥ NO_OF_REGS*4; word_idx SHALL not wrap.
REQ-027 SHALL keep wr_data_o and wr_addr_o stable only when wr_en_o=1; otherwise their value is don't-care.

Reset
REQ-028 SHALL, on rst=1, asynchronously force the state to IDLE, all counters to 0, and wr_en_o, byte_ready_o, busy_o, done_o, err_o and core_rst_o to 0.
REQ-029 SHALL, on rst mid-load, abort the transfer with no further write; words already written are not reverted.

Configuration
REQ-030 SHALL, when macro IMEM_LOADER_CHECKSUM_EN is defined, add state CSUM after the last WRITE.
REQ-031 SHALL, in CSUM, accept one byte and compare it to the XOR of all data bytes (length bytes excluded); a match SHALL go to DONE, a mismatch SHALL go to ERR.
REQ-032 SHALL, without the macro, have no CSUM state and no checksum logic.

Structure
REQ-033 SHALL place the FSM state enum and the byte-per-word constant (4) in package imem_loader_pkg.
REQ-034 SHALL implement byte-to-word assembly in sub-module byte_packer: shift-in byte, 2-bit count, word_valid pulse.

Verification
REQ-035 SHALL cover: start, length 02 00 00 00, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013@0x0, 0x00100093@0x4, then done_o pulse.
REQ-036 SHALL cover: length 0 -> no wr_en_o, done_o one cycle after the 4th length byte, core_rst_o released.
REQ-037 SHALL cover: length NO_OF_REGS+1 (257 at defaults) -> err_o=1, no write, and the next start_i clears the error.
REQ-038 SHALL cover: byte_valid_i toggled randomly with gaps -> identical writes as the gap-free case.
REQ-039 SHALL cover: rst asserted after 5 data bytes -> all outputs 0 immediately, no write from the partial word.
REQ-040 SHALL cover, with IMEM_LOADER_CHECKSUM_EN: one word AA BB CC DD with checksum 0x00 -> done_o, checksum 0x01 -> err_o.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared FSM state type and word-assembly constant for the instruction memory loader.
// Defining IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

    localparam int unsigned BytesPerWord = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in bits [7:0].
// word_valid_o is raised combinationally in the cycle the final byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam int unsigned ShiftBits = (BytesPerWord - 1) * 8;

    logic [ShiftBits-1:0] shift_q;
    logic [1:0]           cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_en_i) begin
            shift_q <= {byte_i, shift_q[ShiftBits-1:8]};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

    // The last byte bypasses the shifter so the word is usable in its acceptance cycle.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_en_i && (cnt_q == 2'(BytesPerWord - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory, holding the core in reset.
// Optional IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte after the last data word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned REG_SIZE       = 32,
    parameter int unsigned MEM_SIZE_IN_KB = 1,
    parameter int unsigned NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [7:0]          byte_i,
    input  logic                byte_valid_i,
    output logic                byte_ready_o,
    output logic                wr_en_o,
    output logic [REG_SIZE-1:0] wr_addr_o,
    output logic [REG_SIZE-1:0] wr_data_o,
    output logic                core_rst_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    state_t              state_q;
    logic [REG_SIZE-1:0] len_q;
    logic [REG_SIZE-1:0] word_idx_q;
    logic [REG_SIZE-1:0] idx_next;
    logic                accept;
    logic                pack_en;
    logic                word_valid;
    logic [31:0]         word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    assign accept   = byte_valid_i && byte_ready_o;
    assign pack_en  = accept && ((state_q == LEN) || (state_q == DATA));
    assign idx_next = word_idx_q + REG_SIZE'(1);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_en_i    (pack_en),
        .byte_i       (byte_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_ready_o <= 1'b0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            core_rst_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            wr_en_o <= 1'b0;
            done_o  <= 1'b0;
            case (state_q)
                IDLE, ERR: begin
                    if (start_i) begin
                        state_q      <= LEN;
                        word_idx_q   <= '0;
                        byte_ready_o <= 1'b1;
                        busy_o       <= 1'b1;
                        core_rst_o   <= 1'b1;
                        err_o        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q       <= '0;
`endif
                    end
                end
                LEN: begin
                    if (word_valid) begin
                        len_q <= REG_SIZE'(word);
                        if (word == '0) begin
                            state_q      <= DONE;
                            done_o       <= 1'b1;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            core_rst_o   <= 1'b0;
                        end else if (word > 32'(NO_OF_REGS)) begin
                            state_q      <= ERR;
                            err_o        <= 1'b1;
                            byte_ready_o <= 1'b0;
                            busy_o       <= 1'b0;
                            core_rst_o   <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) csum_q <= csum_q ^ byte_i;
`endif
                    if (word_valid) begin
                        state_q      <= WRITE;
                        wr_en_o      <= 1'b1;
                        wr_addr_o    <= word_idx_q << 2;
                        wr_data_o    <= REG_SIZE'(word);
                        byte_ready_o <= 1'b0;
                    end
                end
                WRITE: begin
                    word_idx_q <= idx_next;
                    if (idx_next < len_q) begin
                        state_q      <= DATA;
                        byte_ready_o <= 1'b1;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q      <= CSUM;
                        byte_ready_o <= 1'b1;
`else
                        state_q      <= DONE;
                        done_o       <= 1'b1;
`endif
                        busy_o       <= 1'b0;
                        core_rst_o   <= 1'b0;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        byte_ready_o <= 1'b0;
                        if (byte_i == csum_q) begin
                            state_q <= DONE;
                            done_o  <= 1'b1;
                        end else begin
                            state_q <= ERR;
                            err_o   <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner sequences and
// randomized loads against a word-level reference model (honours IMEM_LOADER_CHECKSUM_EN).
module tb_imem_loader;

    localparam int unsigned NoOfRegs = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  byte_i = 8'h00;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .wr_en_o      (wr_en_o),
        .wr_addr_o    (wr_addr_o),
        .wr_data_o    (wr_data_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: records every write and flags malformed strobes.
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_cnt = 0;
    logic        wr_en_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o) begin
                got_addr.push_back(wr_addr_o);
                got_data.push_back(wr_data_o);
                check("write_single_cycle", 32'(wr_en_prev), 32'd0);
                check("write_addr_in_range", 32'(wr_addr_o < NoOfRegs * 4), 32'd1);
                check("core_held_during_write", {30'd0, busy_o, core_rst_o}, 32'd3);
            end
            if (done_o) done_cnt++;
            wr_en_prev = wr_en_o;
        end else begin
            wr_en_prev = 1'b0;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int gap_pct);
        int i = 0;
        int cycles = 0;
        while (i < b.size() && cycles < 5000) begin
            @(negedge clk);
            byte_i       = b[i];
            byte_valid_i = ($urandom_range(99) >= gap_pct);
            if (byte_valid_i && byte_ready_o) i++;
            cycles++;
        end
        @(negedge clk);
        byte_valid_i = 1'b0;
        check("stream_accepted", 32'(i), 32'(b.size()));
    endtask

    // Full load: builds the byte stream from words, predicts writes and outcome, then compares.
    task automatic run_case(input string name, input int unsigned len, input logic [31:0] words[$],
                            input int gap, input bit bad_csum);
        logic [7:0] s[$];
        logic [7:0] x;
        bit         len_err;
        bit         exp_err;
        int         d0;
        int         n;
        int         exp_n;
        x = 8'h00;
        for (int k = 0; k < 4; k++) s.push_back(8'(len >> (8 * k)));
        len_err = (len > NoOfRegs);
        exp_err = len_err;
        if (!len_err) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) begin
                    s.push_back(words[i][8*k +: 8]);
                    x ^= words[i][8*k +: 8];
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (len != 0) begin
                s.push_back(bad_csum ? (x ^ 8'h01) : x);
                exp_err = bad_csum;
            end
`else
            if (bad_csum) $display("note: %s checksum corruption has no effect in this build", name);
`endif
        end
        exp_n = len_err ? 0 : words.size();
        got_addr.delete();
        got_data.delete();
        d0 = done_cnt;
        pulse_start();
        #1;
        check({name, ":err_cleared"}, 32'(err_o), 32'd0);
        check({name, ":busy_on_start"}, {30'd0, busy_o, core_rst_o}, 32'd3);
        check({name, ":ready_on_start"}, 32'(byte_ready_o), 32'd1);
        send_bytes(s, gap);
        n = 0;
        while (done_cnt == d0 && !err_o && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, ":outcome_seen"}, 32'(n < 50), 32'd1);
        check({name, ":err"}, 32'(err_o), 32'(exp_err));
        check({name, ":done_pulses"}, 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
        check({name, ":write_count"}, 32'(got_data.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got_data.size(); i++) begin
            check({name, ":addr"}, got_addr[i], 32'(4 * i));
            check({name, ":data"}, got_data[i], words[i]);
        end
        repeat (2) @(negedge clk);
        check({name, ":released"}, {30'd0, busy_o, core_rst_o}, 32'd0);
    endtask

    typedef struct {
        string       name;
        int unsigned len;
        int          gap;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_err;
        int unsigned exp_writes;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] words[$];
    logic [7:0]  s[$];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"two_words",   2,            0,  32'h0000_0013, 32'h0010_0093, 1'b0, 2};
        vecs[1] = '{"len_zero",    0,            0,  32'h0,         32'h0,         1'b0, 0};
        vecs[2] = '{"len_over",    NoOfRegs + 1, 0,  32'h0,         32'h0,         1'b1, 0};
        vecs[3] = '{"two_gappy",   2,            60, 32'h0000_0013, 32'h0010_0093, 1'b0, 2};
        vecs[4] = '{"one_word",    1,            30, 32'hDEAD_BEEF, 32'h0,         1'b0, 1};
        vecs[5] = '{"full_memory", NoOfRegs,     10, 32'h1234_5678, 32'h8765_4321, 1'b0, NoOfRegs};

        #1 rst = 1'b1;
        #1;
        check("reset:wr_en", 32'(wr_en_o), 32'd0);
        check("reset:ready", 32'(byte_ready_o), 32'd0);
        check("reset:busy_core_rst", {30'd0, busy_o, core_rst_o}, 32'd0);
        check("reset:done_err", {30'd0, done_o, err_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle:not_ready", 32'(byte_ready_o), 32'd0);

        foreach (vecs[v]) begin
            words.delete();
            if (vecs[v].len <= NoOfRegs) begin
                for (int i = 0; i < vecs[v].len; i++) begin
                    words.push_back(i == 0 ? vecs[v].w0 : i == 1 ? vecs[v].w1 : 32'(i) * 32'h9E37_79B9);
                end
            end
            run_case(vecs[v].name, vecs[v].len, words, vecs[v].gap, 1'b0);
            check({vecs[v].name, ":table_err"}, 32'(err_o), 32'(vecs[v].exp_err));
            check({vecs[v].name, ":table_writes"}, 32'(got_data.size()), vecs[v].exp_writes);
        end

        // Zero length: done_o must rise in the cycle right after the fourth length byte.
        pulse_start();
        got_data.delete();
        s = {8'h00, 8'h00, 8'h00, 8'h00};
        send_bytes(s, 0);
        check("len0_timing:done", 32'(done_o), 32'd1);
        check("len0_timing:core_rst", 32'(core_rst_o), 32'd0);
        @(negedge clk);
        check("len0_timing:done_one_cycle", 32'(done_o), 32'd0);
        check("len0_timing:no_write", 32'(got_data.size()), 32'd0);

        // start_i during the length phase is ignored; then reset lands mid-word.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        s = {8'h02, 8'h00};
        send_bytes(s, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        s = {8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        send_bytes(s, 0);
        check("mid_rst:busy_before", 32'(busy_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst:outputs", {26'd0, wr_en_o, byte_ready_o, busy_o, done_o, err_o, core_rst_o},
              32'd0);
        check("mid_rst:writes", 32'(got_data.size()), 32'd1);
        if (got_data.size() > 0) begin
            check("mid_rst:data", got_data[0], 32'h0000_0013);
            check("mid_rst:addr", got_addr[0], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        byte_valid_i = 1'b1;
        repeat (10) @(negedge clk);
        byte_valid_i = 1'b0;
        check("mid_rst:no_more_writes", 32'(got_data.size()), 32'd1);
        check("mid_rst:idle", {30'd0, busy_o, byte_ready_o}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = {32'hDDCC_BBAA};
        run_case("csum_good", 1, words, 0, 1'b0);
        run_case("csum_bad", 1, words, 0, 1'b1);
`endif

        for (int r = 0; r < 25; r++) begin
            int unsigned len;
            bit          bad;
            len = ($urandom_range(7) == 0) ? NoOfRegs + $urandom_range(1, 1000)
                                           : $urandom_range(0, 6);
            words.delete();
            if (len <= NoOfRegs) begin
                for (int i = 0; i < len; i++) words.push_back($urandom);
            end
            bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(3) == 0);
`endif
            run_case($sformatf("rand%0d", r), len, words, $urandom_range(0, 70), bad);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
